io_switch_conditioner: RTL and testbench

- Front end of the memory-mapped input path. Sits between the board pins (slide switches, push keys) and the I/O input register/mux stage.
- Synchronises and debounces two switch operand buses and zero-extends them to 32-bit in_port0/in_port1.
- Debounces two mode keys and turns each key press into a one-hot mode select (and_model / add_model).
- All outputs are registered and glitch-free, so the downstream stage can sample them on any io_clk edge.

---
 rtl/io_switch_conditioner_pkg.sv | 22 ++
 rtl/io_debounce_unit.sv | 59 +++++
 rtl/io_switch_conditioner.sv | 104 ++++++++++
 tb/tb_io_switch_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_switch_conditioner_pkg.sv
// Shared constants and helpers for the I/O input conditioning path.
//   IO_DATA_W          : width of the memory-mapped input ports.
//   MODE_RESET_ADD     : mode selected out of reset (1 = ADD mode).
//   DEB_CYCLES_DEFAULT : default number of stable cycles for debouncing.
//   KEY_AND_IDX/ADD    : bit positions of the two keys in the key vector.
package io_switch_conditioner_pkg;

    localparam int       IO_DATA_W          = 32;
    localparam logic     MODE_RESET_ADD     = 1'b1;
    localparam int       DEB_CYCLES_DEFAULT = 4;

    localparam int       KEY_AND_IDX        = 0;
    localparam int       KEY_ADD_IDX        = 1;

    // Convert raw key levels into "1 = pressed" so that a cleared
    // synchroniser always means "not pressed".
    function automatic logic [1:0] key_normalise(input logic [1:0] raw,
                                                 input bit         active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/io_debounce_unit.sv
// Synchronise and debounce a WIDTH-bit group of asynchronous inputs.
// The whole group is treated as one value, so dout never shows a
// partially-updated bus.
//   io_clk : clock, rising edge
//   resetn : asynchronous active-low reset
//   din    : raw asynchronous input group
//   dout   : debounced group, updated once din has been stable at the
//            synchroniser output for DEB_CYCLES+1 consecutive edges
module io_debounce_unit #(
    parameter int WIDTH      = 5,
    parameter int DEB_CYCLES = 4
) (
    input  logic             io_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int             CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here, synchroniser included, is cleared by the async
    // reset so that a reset mid-window discards the pending candidate and the
    // window restarts from a known state after release.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            // NOTE: non-blocking assignments keep s1 -> s2 a true two-stage
            // pipeline; blocking ones would collapse it into a single flop.
            s1 <= din;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else begin
                if (cnt < CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
                // The last counting edge of the window commits the candidate;
                // once saturated the output already equals cand.
                if (cnt == CNT_LAST) begin
                    dout <= cand;
                end
            end
        end
    end

endmodule

// File: rtl/io_switch_conditioner.sv
// Front end of the memory-mapped input path.
// Debounces two switch operand buses (zero-extended to IO_DATA_W) and two
// mode keys; each key press selects a one-hot mode.
//   io_clk       : clock, rising edge
//   resetn       : asynchronous active-low reset
//   sw0_raw      : operand 0 switches (asynchronous)
//   sw1_raw      : operand 1 switches (asynchronous)
//   key_and_raw  : AND-mode key (asynchronous)
//   key_add_raw  : ADD-mode key (asynchronous)
//   in_port0     : debounced sw0, zero-extended
//   in_port1     : debounced sw1, zero-extended
//   and_model    : AND mode selected
//   add_model    : ADD mode selected
//   mode_changed : one-cycle pulse, coincident with the first cycle of a new mode
module io_switch_conditioner
    import io_switch_conditioner_pkg::*;
#(
    parameter int SW_WIDTH       = 5,
    parameter int DEB_CYCLES     = DEB_CYCLES_DEFAULT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                 io_clk,
    input  logic                 resetn,
    input  logic [SW_WIDTH-1:0]  sw0_raw,
    input  logic [SW_WIDTH-1:0]  sw1_raw,
    input  logic                 key_and_raw,
    input  logic                 key_add_raw,
    output logic [IO_DATA_W-1:0] in_port0,
    output logic [IO_DATA_W-1:0] in_port1,
    output logic                 and_model,
    output logic                 add_model,
    output logic                 mode_changed
);

    logic [SW_WIDTH-1:0] sw0_db;
    logic [SW_WIDTH-1:0] sw1_db;
    logic [1:0]          key_pressed;
    logic [1:0]          key_db;
    logic [1:0]          key_prev;
    logic [1:0]          key_rise;
    logic                and_next;
    logic                add_next;

    // Keys are made active-high before synchronising so reset state = released.
    assign key_pressed = key_normalise({key_add_raw, key_and_raw}, KEY_ACTIVE_LOW);

    io_debounce_unit #(.WIDTH(SW_WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_deb_sw0 (
        .io_clk (io_clk),
        .resetn (resetn),
        .din    (sw0_raw),
        .dout   (sw0_db)
    );

    io_debounce_unit #(.WIDTH(SW_WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_deb_sw1 (
        .io_clk (io_clk),
        .resetn (resetn),
        .din    (sw1_raw),
        .dout   (sw1_db)
    );

    io_debounce_unit #(.WIDTH(2), .DEB_CYCLES(DEB_CYCLES)) u_deb_key (
        .io_clk (io_clk),
        .resetn (resetn),
        .din    (key_pressed),
        .dout   (key_db)
    );

    // Debounced values are already registered, so the ports stay glitch-free.
    assign in_port0 = {{(IO_DATA_W - SW_WIDTH){1'b0}}, sw0_db};
    assign in_port1 = {{(IO_DATA_W - SW_WIDTH){1'b0}}, sw1_db};

    // Only press edges act; release edges and held keys are ignored.
    assign key_rise = key_db & ~key_prev;

    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no
        // latch is inferred.
        and_next = and_model;
        add_next = add_model;
        if (key_rise[KEY_AND_IDX] && !key_rise[KEY_ADD_IDX]) begin
            and_next = 1'b1;
            add_next = 1'b0;
        end else if (key_rise[KEY_ADD_IDX] && !key_rise[KEY_AND_IDX]) begin
            and_next = 1'b0;
            add_next = 1'b1;
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            key_prev     <= '0;
            and_model    <= ~MODE_RESET_ADD;
            add_model    <= MODE_RESET_ADD;
            mode_changed <= 1'b0;
        end else begin
            key_prev     <= key_db;
            and_model    <= and_next;
            add_model    <= add_next;
            // Pulse only on a real flip; re-pressing the selected key is silent.
            mode_changed <= (and_next != and_model) || (add_next != add_model);
        end
    end

endmodule

// File: tb/tb_io_switch_conditioner.sv
// Directed-vector bench with a scoreboard: stimulus pushes the expected
// value and the edge count at which it must appear; a monitor pops and
// compares whenever an output changes or mode_changed pulses.
module tb_io_switch_conditioner;

    localparam int SW_WIDTH = 5;
    localparam int DEB      = 4;
    localparam int LAT      = DEB + 3;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic                io_clk;
    logic                resetn;
    logic [SW_WIDTH-1:0] sw0_raw;
    logic [SW_WIDTH-1:0] sw1_raw;
    logic                key_and_raw;
    logic                key_add_raw;
    logic [31:0]         in_port0;
    logic [31:0]         in_port1;
    logic                and_model;
    logic                add_model;
    logic                mode_changed;

    io_switch_conditioner #(
        .SW_WIDTH       (SW_WIDTH),
        .DEB_CYCLES     (DEB),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .io_clk       (io_clk),
        .resetn       (resetn),
        .sw0_raw      (sw0_raw),
        .sw1_raw      (sw1_raw),
        .key_and_raw  (key_and_raw),
        .key_add_raw  (key_add_raw),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .and_model    (and_model),
        .add_model    (add_model),
        .mode_changed (mode_changed)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int cycle = 0;
    always @(posedge io_clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t qm[$];  // val = {and_model, add_model}
    exp_t qp[$];  // mode_changed pulses, cyc only

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, value 0x%08h, expected no event (cycle %0d)",
                 name, act, cycle);
    endtask

    task automatic push(inout exp_t q[$], input logic [31:0] val, input int cyc);
        exp_t e;
        e.val = val;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  pm;
        exp_t        e;
        p0 = '0;
        p1 = '0;
        pm = 2'b01;
        forever begin
            @(posedge io_clk);
            #1;
            if (in_port0 !== p0) begin
                if (q0.size() == 0) unexpected("in_port0", in_port0);
                else begin
                    e = q0.pop_front();
                    check("in_port0_val", in_port0, e.val);
                    check("in_port0_cyc", 32'(cycle), 32'(e.cyc));
                end
                p0 = in_port0;
            end
            if (in_port1 !== p1) begin
                if (q1.size() == 0) unexpected("in_port1", in_port1);
                else begin
                    e = q1.pop_front();
                    check("in_port1_val", in_port1, e.val);
                    check("in_port1_cyc", 32'(cycle), 32'(e.cyc));
                end
                p1 = in_port1;
            end
            if ({and_model, add_model} !== pm) begin
                if (qm.size() == 0) unexpected("mode_flags", 32'({and_model, add_model}));
                else begin
                    e = qm.pop_front();
                    check("mode_flags_val", 32'({and_model, add_model}), e.val);
                    check("mode_flags_cyc", 32'(cycle), 32'(e.cyc));
                end
                pm = {and_model, add_model};
            end
            if (mode_changed === 1'b1) begin
                if (qp.size() == 0) unexpected("mode_changed", 32'(mode_changed));
                else begin
                    e = qp.pop_front();
                    check("mode_changed_cyc", 32'(cycle), 32'(e.cyc));
                end
            end
            if (and_model === 1'b1 && add_model === 1'b1)
                unexpected("one_hot", 32'({and_model, add_model}));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    initial begin
        resetn      = 1'b0;
        sw0_raw     = 5'h1F;
        sw1_raw     = '0;
        key_and_raw = 1'b1;
        key_add_raw = 1'b1;

        // Reset with sw0 driven: nothing may propagate.
        wait_cycles(4);
        check("rst_in_port0", in_port0, 32'h0);
        check("rst_in_port1", in_port1, 32'h0);
        check("rst_and_model", 32'(and_model), 32'h0);
        check("rst_add_model", 32'(add_model), 32'h1);
        check("rst_mode_changed", 32'(mode_changed), 32'h0);
        sw0_raw = '0;
        resetn  = 1'b1;
        wait_cycles(3);

        // Reset in the middle of a debounce window.
        sw0_raw = 5'h0A;
        wait_cycles(3);
        resetn = 1'b0;
        #1;
        check("midrst_in_port0", in_port0, 32'h0);
        wait_cycles(2);
        push(q0, 32'h0000_000A, cycle + LAT);
        resetn = 1'b1;
        wait_cycles(10);

        // Clean change on sw0.
        sw0_raw = 5'h15;
        push(q0, 32'h0000_0015, cycle + LAT);
        wait_cycles(10);

        // sw1 bouncing: 2-cycle pulses never qualify, then it settles.
        for (int i = 0; i < 10; i++) begin
            sw1_raw = (i % 2 == 0) ? 5'h03 : 5'h00;
            wait_cycles(2);
        end
        sw1_raw = 5'h03;
        push(q1, 32'h0000_0003, cycle + LAT);
        wait_cycles(10);

        // Independent changes on both buses, offset by three cycles.
        sw1_raw = 5'h1C;
        push(q1, 32'h0000_001C, cycle + LAT);
        wait_cycles(3);
        sw0_raw = 5'h01;
        push(q0, 32'h0000_0001, cycle + LAT);
        wait_cycles(10);

        // AND press: flags flip one edge after the debounced key rises.
        key_and_raw = 1'b0;
        push(qm, 32'h2, cycle + LAT + 1);
        push(qp, 32'h0, cycle + LAT + 1);
        wait_cycles(10);
        key_and_raw = 1'b1;
        wait_cycles(12);

        // AND pressed again: already selected, no effect.
        key_and_raw = 1'b0;
        wait_cycles(10);
        key_and_raw = 1'b1;
        wait_cycles(12);

        // ADD press.
        key_add_raw = 1'b0;
        push(qm, 32'h1, cycle + LAT + 1);
        push(qp, 32'h0, cycle + LAT + 1);
        wait_cycles(10);
        key_add_raw = 1'b1;
        wait_cycles(12);

        // Both keys on the same edge: no change, no pulse.
        key_and_raw = 1'b0;
        key_add_raw = 1'b0;
        wait_cycles(12);
        key_and_raw = 1'b1;
        key_add_raw = 1'b1;
        wait_cycles(12);

        check("final_in_port0", in_port0, 32'h0000_0001);
        check("final_in_port1", in_port1, 32'h0000_001C);
        check("final_add_model", 32'(add_model), 32'h1);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("qm_drained", 32'(qm.size()), 32'h0);
        check("qp_drained", 32'(qp.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
